// File: rtl/control_acceso_parqueo_if.sv
// Sensor, keypad and gate/alarm signals shared between the access controller and its environment.
interface control_acceso_parqueo_if;
  logic        sensor_llegada_vehiculo;
  logic        sensor_ingreso_vehiculo;
  logic [15:0] clave_ingresada;
  logic        clave_valida;
  logic        senal_compuerta;
  logic        senal_alarma_pin;
  logic        senal_alarma_bloqueo;

  modport master (
    output sensor_llegada_vehiculo, sensor_ingreso_vehiculo, clave_ingresada, clave_valida,
    input  senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo
  );

  modport slave (
    input  sensor_llegada_vehiculo, sensor_ingreso_vehiculo, clave_ingresada, clave_valida,
    output senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo
  );
endinterface

// File: rtl/control_acceso_parqueo.sv
// Parking-entrance Moore FSM: PIN check, gate-open timer, wrong-PIN and tailgate alarms.
// Outputs are registered from the next state (1-cycle latency); no backpressure, every input cycle is consumed.
module control_acceso_parqueo #(
  parameter logic [15:0] CLAVE_CORRECTA = 16'h1234,
  parameter int          MAX_INTENTOS   = 3,
  parameter int          TIEMPO_ABIERTA = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  control_acceso_parqueo_if.slave  bus
);
  localparam int TW = $clog2(TIEMPO_ABIERTA) + 1;

  typedef enum logic [2:0] {
    INICIO, ESPERA_CLAVE, ABIERTA, INGRESANDO, ALARMA_PIN, BLOQUEO
  } state_t;

  state_t          state, nxt_state;
  logic [3:0]      intentos, nxt_intentos, intentos_inc;
  logic [TW-1:0]   timer, nxt_timer;
  logic            llegada, ingreso, pin_ok, pin_bad;

  assign llegada      = bus.sensor_llegada_vehiculo;
  assign ingreso      = bus.sensor_ingreso_vehiculo;
  assign pin_ok       = bus.clave_valida && (bus.clave_ingresada == CLAVE_CORRECTA);
  assign pin_bad      = bus.clave_valida && (bus.clave_ingresada != CLAVE_CORRECTA);
  assign intentos_inc = intentos + 4'd1;

  always_comb begin
    nxt_state    = state;
    nxt_intentos = intentos;
    nxt_timer    = timer;
    case (state)
      INICIO: begin
        if (llegada) begin
          nxt_state    = ESPERA_CLAVE;
          nxt_intentos = 4'd0;
        end
      end
      ESPERA_CLAVE: begin
        if (!llegada) begin
          nxt_state = INICIO;
        end else if (pin_ok) begin
          nxt_state    = ABIERTA;
          nxt_intentos = 4'd0;
          nxt_timer    = '0;
        end else if (pin_bad) begin
          nxt_intentos = intentos_inc;
          if (intentos_inc == 4'(MAX_INTENTOS))
            nxt_state = ALARMA_PIN;
        end
      end
      ALARMA_PIN: begin
        if (pin_ok) begin
          nxt_state    = ABIERTA;
          nxt_intentos = 4'd0;
          nxt_timer    = '0;
        end else if (pin_bad && intentos < 4'(MAX_INTENTOS)) begin
          nxt_intentos = intentos_inc;
        end
      end
      ABIERTA: begin
        if (ingreso && llegada) begin
          nxt_state = BLOQUEO;
        end else if (ingreso) begin
          nxt_state = INGRESANDO;
        end else if (timer == TW'(TIEMPO_ABIERTA - 1)) begin
          // Gate closes without an entry; the driver must key the PIN again.
          nxt_state = ESPERA_CLAVE;
        end else begin
          nxt_timer = timer + 1'b1;
        end
      end
      INGRESANDO: begin
        if (ingreso && llegada)
          nxt_state = BLOQUEO;
        else if (!ingreso)
          nxt_state = INICIO;
      end
      BLOQUEO: begin
        if (pin_ok)
          nxt_state = INICIO;
      end
      default: nxt_state = INICIO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                    <= INICIO;
      intentos                 <= 4'd0;
      timer                    <= '0;
      bus.senal_compuerta      <= 1'b0;
      bus.senal_alarma_pin     <= 1'b0;
      bus.senal_alarma_bloqueo <= 1'b0;
    end else begin
      state                    <= nxt_state;
      intentos                 <= nxt_intentos;
      timer                    <= nxt_timer;
      bus.senal_compuerta      <= (nxt_state == ABIERTA);
      bus.senal_alarma_pin     <= (nxt_state == ALARMA_PIN);
      bus.senal_alarma_bloqueo <= (nxt_state == BLOQUEO);
    end
  end
endmodule
